// File: rtl/pipeadd.sv
// pipeadd: parameterised, fully pipelined adder/subtractor with a segmented
// carry chain. Each of NSTAGES stages adds one CW-bit slice and hands its
// carry to the next stage one clock later; operand slices are skewed in and
// result slices are deskewed out so a whole sample emerges at once.
// Optional feature macro: PIPEADD_OVFL_EN adds the o_ovfl signed-overflow
// output, registered alongside the last stage.
module pipeadd #(
    parameter int BW      = 64,
    parameter int NSTAGES = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_ce,
    input  logic          i_sync,
    input  logic          i_sub,
    input  logic [BW-1:0] i_a,
    input  logic [BW-1:0] i_b,
    output logic [BW-1:0] o_r,
    output logic          o_carry,
    output logic          o_sync
`ifdef PIPEADD_OVFL_EN
    ,
    output logic          o_ovfl
`endif
);

    localparam int CW = BW / NSTAGES;

    // Reject unsupported geometries at elaboration time.
    if ((NSTAGES < 1) || (NSTAGES > 8) || (BW < 1) || ((BW % NSTAGES) != 0)) begin : g_param_check
        $error("pipeadd: BW must be a multiple of NSTAGES and NSTAGES must be 1..8");
    end

    logic [BW-1:0]      b_eff_s;   // B, inverted for subtract
    logic [NSTAGES-1:0] carry_s;   // registered carry out of every stage
    logic [BW-1:0]      r_s;       // deskewed result slices
    logic [NSTAGES-1:0] sync_q;    // sync strobe delay line

    // Subtract is A + ~B + 1; the +1 enters as the carry into stage 0.
    always_comb begin
        b_eff_s = i_b ^ {BW{i_sub}};
    end

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        logic [CW-1:0] a_in_s;
        logic [CW-1:0] b_in_s;
        logic          c_in_s;
        logic [CW:0]   sum_d;
        logic [CW-1:0] sum_q;
        logic          carry_q;

        if (k == 0) begin : g_noskew
            // Lowest slice consumes the operands directly; carry-in is the mode bit.
            always_comb begin
                a_in_s = i_a[CW-1:0];
                b_in_s = b_eff_s[CW-1:0];
                c_in_s = i_sub;
            end
        end else begin : g_skew
            logic [CW-1:0] a_skew_q [k];
            logic [CW-1:0] b_skew_q [k];

            // Delay this slice's operands by k clocks so they meet the carry from below.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    for (int i = 0; i < k; i++) begin
                        a_skew_q[i] <= '0;
                        b_skew_q[i] <= '0;
                    end
                end else if (i_ce) begin
                    a_skew_q[0] <= i_a[k*CW +: CW];
                    b_skew_q[0] <= b_eff_s[k*CW +: CW];
                    for (int i = 1; i < k; i++) begin
                        a_skew_q[i] <= a_skew_q[i-1];
                        b_skew_q[i] <= b_skew_q[i-1];
                    end
                end
            end

            // Feed the oldest skewed operands and the previous stage's carry.
            always_comb begin
                a_in_s = a_skew_q[k-1];
                b_in_s = b_skew_q[k-1];
                c_in_s = carry_s[k-1];
            end
        end

        // Slice add with one extra bit to capture the carry out.
        always_comb begin
            sum_d = {1'b0, a_in_s} + {1'b0, b_in_s} + {{CW{1'b0}}, c_in_s};
        end

        // Stage register: slice sum and carry for the next stage.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                sum_q   <= '0;
                carry_q <= 1'b0;
            end else if (i_ce) begin
                sum_q   <= sum_d[CW-1:0];
                carry_q <= sum_d[CW];
            end
        end

        assign carry_s[k] = carry_q;

        if (k == NSTAGES - 1) begin : g_nodeskew
            assign r_s[k*CW +: CW] = sum_q;
        end else begin : g_deskew
            localparam int D = NSTAGES - 1 - k;
            logic [CW-1:0] dsk_q [D];

            // Hold finished low slices until the top slice of the same sample completes.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    for (int i = 0; i < D; i++) begin
                        dsk_q[i] <= '0;
                    end
                end else if (i_ce) begin
                    dsk_q[0] <= sum_q;
                    for (int i = 1; i < D; i++) begin
                        dsk_q[i] <= dsk_q[i-1];
                    end
                end
            end

            assign r_s[k*CW +: CW] = dsk_q[D-1];
        end

`ifdef PIPEADD_OVFL_EN
        if (k == NSTAGES - 1) begin : g_ovfl
            logic ovfl_d;
            logic ovfl_q;

            // Signed overflow: carry into the MSB differs from carry out of it.
            always_comb begin
                ovfl_d = (a_in_s[CW-1] ^ b_in_s[CW-1] ^ sum_d[CW-1]) ^ sum_d[CW];
            end

            // Register overflow in step with the top slice.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset) begin
                    ovfl_q <= 1'b0;
                end else if (i_ce) begin
                    ovfl_q <= ovfl_d;
                end
            end

            assign o_ovfl = ovfl_q;
        end
`endif
    end

    if (NSTAGES == 1) begin : g_sync1
        // Single-stage sync delay.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                sync_q <= '0;
            end else if (i_ce) begin
                sync_q <= i_sync;
            end
        end
    end else begin : g_syncn
        // NSTAGES-deep sync shift register, advancing with the data.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                sync_q <= '0;
            end else if (i_ce) begin
                sync_q <= {sync_q[NSTAGES-2:0], i_sync};
            end
        end
    end

    assign o_r     = r_s;
    assign o_carry = carry_s[NSTAGES-1];
    assign o_sync  = sync_q[NSTAGES-1];

endmodule

// File: tb/tb_pipeadd.sv
// tb_pipeadd: drives five pipeadd instances (NSTAGES 1,2,3,4,8; the 3-stage
// one is 48 bits wide) from shared inputs and checks every output after
// every clock against constants or a small reference adder.
module tb_pipeadd;

    localparam int ND   = 5;
    localparam int HMAX = 1024;

    logic        clk;
    logic        rst;
    logic        ce;
    logic        sync;
    logic        sub;
    logic [63:0] a;
    logic [63:0] b;

    logic [63:0] r1, r2, r4, r8;
    logic [47:0] r3;
    logic [ND-1:0] c_s;
    logic [ND-1:0] y_s;
    logic [63:0]   r_s [ND];
`ifdef PIPEADD_OVFL_EN
    logic [ND-1:0] ov_s;
`endif

    int chk_cnt;
    int pass_cnt;
    int n;
    int base;

    logic [63:0] h_a    [HMAX];
    logic [63:0] h_b    [HMAX];
    logic        h_sub  [HMAX];
    logic        h_sync [HMAX];

    pipeadd #(.BW(64), .NSTAGES(1)) u_d1 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sync(sync), .i_sub(sub),
        .i_a(a), .i_b(b), .o_r(r1), .o_carry(c_s[0]), .o_sync(y_s[0])
`ifdef PIPEADD_OVFL_EN
        , .o_ovfl(ov_s[0])
`endif
    );
    pipeadd #(.BW(64), .NSTAGES(2)) u_d2 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sync(sync), .i_sub(sub),
        .i_a(a), .i_b(b), .o_r(r2), .o_carry(c_s[1]), .o_sync(y_s[1])
`ifdef PIPEADD_OVFL_EN
        , .o_ovfl(ov_s[1])
`endif
    );
    pipeadd #(.BW(48), .NSTAGES(3)) u_d3 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sync(sync), .i_sub(sub),
        .i_a(a[47:0]), .i_b(b[47:0]), .o_r(r3), .o_carry(c_s[2]), .o_sync(y_s[2])
`ifdef PIPEADD_OVFL_EN
        , .o_ovfl(ov_s[2])
`endif
    );
    pipeadd #(.BW(64), .NSTAGES(4)) u_d4 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sync(sync), .i_sub(sub),
        .i_a(a), .i_b(b), .o_r(r4), .o_carry(c_s[3]), .o_sync(y_s[3])
`ifdef PIPEADD_OVFL_EN
        , .o_ovfl(ov_s[3])
`endif
    );
    pipeadd #(.BW(64), .NSTAGES(8)) u_d8 (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_sync(sync), .i_sub(sub),
        .i_a(a), .i_b(b), .o_r(r8), .o_carry(c_s[4]), .o_sync(y_s[4])
`ifdef PIPEADD_OVFL_EN
        , .o_ovfl(ov_s[4])
`endif
    );

    assign r_s[0] = r1;
    assign r_s[1] = r2;
    assign r_s[2] = {16'd0, r3};
    assign r_s[3] = r4;
    assign r_s[4] = r8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        case (k)
            0:       return 1;
            1:       return 2;
            2:       return 3;
            3:       return 4;
            4:       return 8;
            default: return 1;
        endcase
    endfunction

    function automatic int width_of(input int k);
        return (k == 2) ? 48 : 64;
    endfunction

    // Reference: plain wide add of A and (possibly inverted) B at width w.
    function automatic void model(input int w, input logic [63:0] av, input logic [63:0] bv,
                                  input logic sv, output logic [63:0] rv, output logic cv,
                                  output logic ov);
        logic [63:0] mask;
        logic [63:0] am;
        logic [63:0] be;
        logic [64:0] full;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        am   = av & mask;
        be   = (sv ? ~bv : bv) & mask;
        full = {1'b0, am} + {1'b0, be} + {64'd0, sv};
        rv   = full[63:0] & mask;
        cv   = full[w];
        ov   = (am[w-1] == be[w-1]) && (rv[w-1] != am[w-1]);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Compare every instance against the sample that entered lat ce-cycles ago.
    task automatic check_all(input string ph);
        for (int k = 0; k < ND; k++) begin
            int          lat;
            logic [63:0] er;
            logic        ec;
            logic        ey;
            logic        eo;
            lat = lat_of(k);
            if ((n - base) >= lat) begin
                model(width_of(k), h_a[n-lat], h_b[n-lat], h_sub[n-lat], er, ec, eo);
                ey = h_sync[n-lat];
            end else begin
                er = 64'd0;
                ec = 1'b0;
                eo = 1'b0;
                ey = 1'b0;
            end
            check($sformatf("%s_d%0d_r", ph, k), r_s[k], er);
            check($sformatf("%s_d%0d_carry", ph, k), {63'd0, c_s[k]}, {63'd0, ec});
            check($sformatf("%s_d%0d_sync", ph, k), {63'd0, y_s[k]}, {63'd0, ey});
`ifdef PIPEADD_OVFL_EN
            check($sformatf("%s_d%0d_ovfl", ph, k), {63'd0, ov_s[k]}, {63'd0, eo});
`endif
        end
    endtask

    task automatic step(input string ph, input logic ce_v, input logic sync_v, input logic sub_v,
                        input logic [63:0] a_v, input logic [63:0] b_v);
        ce   = ce_v;
        sync = sync_v;
        sub  = sub_v;
        a    = a_v;
        b    = b_v;
        @(posedge clk);
        #1;
        if (ce_v && (n < HMAX)) begin
            h_a[n]    = a_v;
            h_b[n]    = b_v;
            h_sub[n]  = sub_v;
            h_sync[n] = sync_v;
            n++;
        end
        check_all(ph);
    endtask

    // One hand-computed vector followed by bubbles; 64-bit instances checked
    // against the given constants on the cycle their latency expires.
    task automatic directed(input string tag, input logic [63:0] av, input logic [63:0] bv,
                            input logic sv, input logic [63:0] er, input logic ec, input logic eo);
        for (int j = 1; j <= 8; j++) begin
            if (j == 1) begin
                step(tag, 1'b1, 1'b1, sv, av, bv);
            end else begin
                step(tag, 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
            end
            for (int k = 0; k < ND; k++) begin
                if ((lat_of(k) == j) && (width_of(k) == 64)) begin
                    check($sformatf("%s_const_d%0d_r", tag, k), r_s[k], er);
                    check($sformatf("%s_const_d%0d_carry", tag, k), {63'd0, c_s[k]}, {63'd0, ec});
                    check($sformatf("%s_const_d%0d_sync", tag, k), {63'd0, y_s[k]}, 64'd1);
`ifdef PIPEADD_OVFL_EN
                    check($sformatf("%s_const_d%0d_ovfl", tag, k), {63'd0, ov_s[k]}, {63'd0, eo});
`endif
                end
            end
        end
    endtask

    initial begin
        chk_cnt  = 0;
        pass_cnt = 0;
        n        = 0;
        base     = 0;
        rst      = 1'b1;
        ce       = 1'b0;
        sync     = 1'b0;
        sub      = 1'b0;
        a        = 64'd0;
        b        = 64'd0;

        #2;
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("post_reset");

        directed("cross32", 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 1'b0, 1'b0);
        directed("allones", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
        directed("sub0m1",  64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        directed("addovf",  64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        directed("subovf",  64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
        directed("sub53",   64'd5, 64'd3, 1'b1, 64'd2, 1'b1, 1'b0);

        // Back-to-back stream with mixed add/subtract.
        for (int i = 0; i < 100; i++) begin
            step("stream", 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, {$urandom, $urandom});
        end

        // Same with ~50% clock enable; held cycles carry junk that must be ignored.
        for (int i = 0; i < 100; i++) begin
            step("ce_stream", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
        end
        for (int i = 0; i < 10; i++) begin
            step("ce_drain", 1'b1, 1'b0, 1'b0, 64'd0, 64'd0);
        end

        // Three strobed samples in flight, then an asynchronous reset mid-cycle.
        for (int i = 0; i < 3; i++) begin
            step("prereset", 1'b1, 1'b1, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        end
        #2;
        rst = 1'b1;
        #1;
        for (int k = 0; k < ND; k++) begin
            check($sformatf("midreset_d%0d_r", k), r_s[k], 64'd0);
            check($sformatf("midreset_d%0d_carry", k), {63'd0, c_s[k]}, 64'd0);
            check($sformatf("midreset_d%0d_sync", k), {63'd0, y_s[k]}, 64'd0);
`ifdef PIPEADD_OVFL_EN
            check($sformatf("midreset_d%0d_ovfl", k), {63'd0, ov_s[k]}, 64'd0);
`endif
        end
        @(posedge clk);
        #1;
        rst  = 1'b0;
        base = n;
        for (int i = 0; i < 12; i++) begin
            step("postreset", 1'b1, 1'b0, 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, {$urandom, $urandom});
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pipeadd.md
# pipeadd

Parametrised, fully pipelined wide adder/subtractor with a split carry chain. It generalises the fixed 64-bit, 1- or 2-clock adder to any width and any number of carry-chain segments, and adds a per-sample subtract mode, carry-out and a pipeline clock enable. Counter and timer datapaths (PPS time accumulators, fractional step adders) use it where a full-width carry chain cannot close timing in one clock. The `i_sync` strobe travels alongside the data, so downstream logic sees the result and its strobe on the same cycle.

## Interface
- `BW`, 64: operand and result width; must be a multiple of `NSTAGES`.
- `NSTAGES`, 2: pipeline depth and carry-chain segment count, legal range 1..8.
  - Segment width `CW = BW/NSTAGES`.
  - Any illegal value is an elaboration error.
- `i_clk` input 1: the single clock; all state is on its rising edge.
- `i_reset` input 1: asynchronous, active-high reset.
- `i_ce` input 1: pipeline advance enable.
- `i_sync` input 1: sample strobe; delayed to `o_sync`.
- `i_sub` input 1: 0 = `a+b`, 1 = `a-b`; sampled with the operands.
- `i_a` input `BW`: operand A, unsigned/two's complement.
- `i_b` input `BW`: operand B.
- `o_r` output `BW`: result, modulo 2^BW.
- `o_carry` output 1: carry out of bit `BW-1`. In subtract mode 1 means no borrow (A ≥ B unsigned).
- `o_sync` output 1: `i_sync` delayed to align with `o_r`.
- `o_ovfl` output 1: signed overflow. Present only with `PIPEADD_OVFL_EN`.

## Operation
- Effective B is `i_sub ? ~i_b : i_b`. Carry into segment 0 equals `i_sub`.
- Stage k (0..NSTAGES-1) adds segment k of A and effective B plus the carry registered by stage k-1. It registers a `CW`-bit sum and a 1-bit carry.
- Operand segments k>0 are skew-delayed by k registers before stage k. Completed low segments are deskewed by NSTAGES-1-k registers. All segments of one sample therefore emerge together.
- `o_carry` is the registered carry of the last stage.
- Each register advances only when `i_ce`=1. When `i_ce`=0 every register, including the sync delay line, holds.
- `i_sync` passes through an `NSTAGES`-deep delay line gated by `i_ce`.
- No sample-to-sample dependency: a new operand pair may enter on every `i_ce` cycle.

## Timing
- Latency is exactly `NSTAGES` `i_ce`-qualified cycles from input to `o_r`/`o_carry`/`o_sync`/`o_ovfl`. Throughput is one sample per `i_ce` cycle.
- NSTAGES=1: single registered full-width add.
- Reset asserted, asynchronously: every pipeline, skew and deskew register clears to 0. `o_r`=0, `o_carry`=0, `o_sync`=0, `o_ovfl`=0.
- Reset released: outputs stay 0 until real samples arrive, which takes `NSTAGES` `i_ce` cycles.
- Reset mid-operation: all in-flight samples are discarded and no `o_sync` is produced for them.
- Carry crossing every segment boundary must still resolve correctly. Example: all-ones + 1 → 0 with carry 1.
- `i_ce` toggling every cycle must not duplicate or drop samples.
- `i_sub` may change on every sample. Each sample's mode travels with its own data.

## Configuration
- `PIPEADD_OVFL_EN` defined:
  - `o_ovfl` port exists.
  - The last stage also registers `c_in(MSB) ^ c_out(MSB)`.
  - `o_ovfl` is aligned with `o_r`; reset value 0.
- Not defined: port and logic are absent. All other behaviour is identical.

## Test plan
- BW=64, NSTAGES=2, `i_ce`=1. A=`0x00000000_FFFFFFFF`, B=1, add, sync=1 → after 2 cycles `o_r`=`0x00000001_00000000`, carry=0, `o_sync`=1 for one cycle.
- NSTAGES=4. A=`0xFFFF_FFFF_FFFF_FFFF`, B=1 → after 4 cycles `o_r`=0, carry=1. Then A=0, B=1, sub → `o_r`=`0xFFFF_FFFF_FFFF_FFFF`, carry=0.
- With `PIPEADD_OVFL_EN`:
  - A=`0x7FFF_FFFF_FFFF_FFFF`, B=1, add → `o_r`=`0x8000_0000_0000_0000`, ovfl=1.
  - A=`0x8000_0000_0000_0000`, B=1, sub → `o_r`=`0x7FFF_FFFF_FFFF_FFFF`, ovfl=1.
  - A=5, B=3, sub → `o_r`=2, ovfl=0, carry=1.
- Stream 100 random pairs with random `i_sub`, `i_ce` held at 1 for every sample. Check each output against the reference sum exactly `NSTAGES` cycles later, for NSTAGES 1, 2, 3 (BW=48) and 8.
- Repeat the stream with random `i_ce` (about 50% duty). While `i_ce`=0, outputs hold; sample order and count must be preserved.
- Launch 3 samples with sync=1, then assert `i_reset` asynchronously mid-pipe. All outputs go to 0 immediately, and no `o_sync` pulse appears after release until a new sample reaches the output.
